// File: rtl/mem_xfer_pkg.sv
// -----------------------------------------------------------------------------
// mem_xfer_pkg
// Shared definitions for the RAM-side transfer responder:
//   - FSM state encoding (2-bit) and the state enum built on it
//   - transfer mode codes driven by the address-calculation line
//   - legal range of the SRAM read latency parameter
// -----------------------------------------------------------------------------
package mem_xfer_pkg;

  // State encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_READ  = ST_READ,
    S_WRITE = ST_WRITE,
    S_DRAIN = ST_DRAIN
  } state_t;

  // Transfer mode codes; 2'b11 is reserved and behaves like idle
  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;

  // SRAM read latency must lie in this range
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/rd_return_fifo.sv
// -----------------------------------------------------------------------------
// rd_return_fifo
// Synchronous FIFO holding read data returned by the SRAM until the
// accelerator consumes it. A push and a pop in the same cycle are legal at
// any occupancy, including full.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset (flushes FIFO)
//   push, push_data    write one word
//   pop                remove head word (ignored when empty)
//   head               head word, 0 when empty
//   occupancy          number of stored words
//   full, empty        status flags
// -----------------------------------------------------------------------------
module rd_return_fifo #(
  parameter  int DATA_W    = 32,
  parameter  int BUF_DEPTH = 4,
  localparam int PTR_W     = $clog2(BUF_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  occupancy,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop_ok;

  assign empty  = (occupancy == '0);
  assign full   = (occupancy == CNT_W'(BUF_DEPTH));
  assign pop_ok = pop & ~empty;
  assign head   = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because BUF_DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

  // NOTE: the storage array has no reset; occupancy alone decides which
  // entries are meaningful, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_xfer_responder.sv
// -----------------------------------------------------------------------------
// mem_xfer_responder
// RAM-side responder for the address-calculation line. In read mode it issues
// SRAM reads under a credit rule (in-flight + buffered < BUF_DEPTH) and returns
// data through rd_return_fifo; in write mode it commits address/data pairs.
// The pause outputs are combinational so a calculator advances on the same
// edge its request is taken.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   mode                         00 idle, 01 read, 10 write, 11 idle
//   addr, addr_valid             address from the calculator line
//   wdata, wdata_valid           write data from the accelerator
//   read_pause, write_pause      stall the read / write address calculator
//   rdata, rdata_valid, rdata_ready  read-return stream to the accelerator
//   sram_en, sram_we, sram_addr, sram_wdata, sram_rdata  SRAM interface
//   xfer_count                   accesses completed since leaving IDLE
//   busy                         state is not IDLE
// -----------------------------------------------------------------------------
module mem_xfer_responder
  import mem_xfer_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic              addr_valid,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              read_pause,
  output logic              write_pause,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [31:0]       xfer_count,
  output logic              busy
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_bad_rd_lat
    $error("mem_xfer_responder: RD_LAT out of range");
  end
  if ((BUF_DEPTH < 2) || ((BUF_DEPTH & (BUF_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("mem_xfer_responder: BUF_DEPTH must be a power of two >= 2");
  end

  state_t             state;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   occupancy;
  logic [CNT_W:0]     credits_used;
  logic [RD_LAT-1:0]  rd_pipe;      // one bit per SRAM read still in the pipe
  logic               issue;
  logic               accept;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;

  // NOTE: every signal written here gets a value before any condition, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    credits_used = {1'b0, inflight} + {1'b0, occupancy};
    issue        = 1'b0;
    accept       = 1'b0;
    if (state == S_READ && addr_valid && credits_used < (CNT_W + 1)'(BUF_DEPTH))
      issue = 1'b1;
    if (state == S_WRITE && addr_valid && wdata_valid)
      accept = 1'b1;
  end

  assign read_pause  = ~issue;
  assign write_pause = ~accept;
  assign busy        = (state != S_IDLE);
  assign push        = rd_pipe[RD_LAT-1];
  assign rdata_valid = ~fifo_empty;
  assign pop         = rdata_valid & rdata_ready;

  rd_return_fifo #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_rd_return_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (sram_rdata),
    .pop       (pop),
    .head      (rdata),
    .occupancy (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      rd_pipe    <= '0;
      inflight   <= '0;
      xfer_count <= '0;
    end else begin
      sram_en <= issue | accept;
      sram_we <= accept;
      if (issue | accept) sram_addr  <= addr;
      if (accept)         sram_wdata <= wdata;

      // A read strobed this cycle has its data on sram_rdata RD_LAT cycles
      // later; the last pipe stage marks that cycle and pushes the FIFO.
      rd_pipe[0] <= sram_en & ~sram_we;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];

      // In-flight counts a read from its issue edge until its push edge.
      inflight <= inflight + CNT_W'(issue) - CNT_W'(push);

      if (state == S_IDLE && (mode == MODE_READ || mode == MODE_WRITE))
        xfer_count <= '0;
      else if (pop | accept)
        xfer_count <= xfer_count + 32'd1;

      unique case (state)
        S_IDLE: begin
          if (mode == MODE_READ)       state <= S_READ;
          else if (mode == MODE_WRITE) state <= S_WRITE;
        end
        S_READ:  if (mode != MODE_READ)  state <= S_DRAIN;
        S_WRITE: if (mode != MODE_WRITE) state <= S_IDLE;
        S_DRAIN: if (inflight == '0 && fifo_empty) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // The credit rule keeps pushes from ever landing on a full buffer.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(push && fifo_full && !pop))
        else $error("mem_xfer_responder: read-return buffer overflow");
    end
  end

endmodule

// File: tb/tb_mem_xfer_responder.sv
module tb_mem_xfer_responder;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int RD_LAT    = 2;
  localparam int BUF_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic [DATA_W-1:0] wdata;
  logic              wdata_valid;
  logic              read_pause;
  logic              write_pause;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              rdata_ready;
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic [31:0]       xfer_count;
  logic              busy;

  always #5 clk = ~clk;

  mem_xfer_responder #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RD_LAT    (RD_LAT),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mode        (mode),
    .addr        (addr),
    .addr_valid  (addr_valid),
    .wdata       (wdata),
    .wdata_valid (wdata_valid),
    .read_pause  (read_pause),
    .write_pause (write_pause),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .rdata_ready (rdata_ready),
    .sram_en     (sram_en),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata),
    .xfer_count  (xfer_count),
    .busy        (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {PH_IDLE, PH_RD, PH_WR, PH_DRAIN} phase_e;
  typedef struct {
    int          due;
    logic [31:0] a;
  } pend_t;

  phase_e      ph;
  pend_t       pend_q[$];     // reads issued, waiting for their return cycle
  logic [31:0] buf_q[$];      // data waiting to be consumed
  int unsigned m_xfer;
  bit          m_en, m_we;
  logic [31:0] m_addr, m_wdata;
  int          cyc = 0;
  logic [31:0] sram_key = 32'h0;

  // SRAM environment: read pipe indexed by age in cycles
  bit          pv [0:RD_LAT];
  logic [31:0] pa [0:RD_LAT];

  // values sampled at the last negedge
  logic        s_en, s_we, s_rv, s_rp, s_wp, s_busy;
  logic [31:0] s_addr, s_wdata, s_rdata, s_xfer;

  function automatic void model_reset();
    ph = PH_IDLE;
    pend_q.delete();
    buf_q.delete();
    m_xfer  = 0;
    m_en    = 0;
    m_we    = 0;
    m_addr  = 0;
    m_wdata = 0;
    for (int i = 0; i <= RD_LAT; i++) begin
      pv[i] = 0;
      pa[i] = 0;
    end
  endfunction

  task automatic step();
    bit iss, acc, drain_done;
    @(negedge clk);
    if (!reset_n) model_reset();
    s_en = sram_en; s_we = sram_we; s_rv = rdata_valid; s_rp = read_pause;
    s_wp = write_pause; s_busy = busy; s_addr = sram_addr; s_wdata = sram_wdata;
    s_rdata = rdata; s_xfer = xfer_count;

    iss = reset_n && ph == PH_RD && addr_valid &&
          (pend_q.size() + buf_q.size() < BUF_DEPTH);
    acc = reset_n && ph == PH_WR && addr_valid && wdata_valid;

    check("busy", s_busy, ph != PH_IDLE);
    check("rdata_valid", s_rv, buf_q.size() != 0);
    check("read_pause", s_rp, !iss);
    check("write_pause", s_wp, !acc);
    check("sram_en", s_en, m_en);
    check("sram_we", s_we, m_we);
    check("xfer_count", s_xfer, m_xfer);
    if (buf_q.size() != 0) check("rdata", s_rdata, buf_q[0]);
    if (m_en) check("sram_addr", s_addr, m_addr);
    if (m_en && m_we) check("sram_wdata", s_wdata, m_wdata);

    for (int i = RD_LAT; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = reset_n && sram_en && !sram_we;
    pa[0] = sram_addr;
    sram_rdata = pv[RD_LAT] ? (pa[RD_LAT] ^ sram_key) : $urandom();

    if (reset_n) begin
      drain_done = (pend_q.size() == 0) && (buf_q.size() == 0);
      if (buf_q.size() != 0 && rdata_ready) begin
        buf_q.delete(0);
        m_xfer++;
      end
      if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
        buf_q.push_back(pend_q[0].a ^ sram_key);
        pend_q.delete(0);
      end
      if (iss) begin
        pend_q.push_back('{cyc + 1 + RD_LAT, addr});
        m_en = 1; m_we = 0; m_addr = addr;
      end else if (acc) begin
        m_en = 1; m_we = 1; m_addr = addr; m_wdata = wdata;
        m_xfer++;
      end else begin
        m_en = 0; m_we = 0;
      end
      case (ph)
        PH_IDLE: begin
          if (mode == 2'b01)      begin ph = PH_RD; m_xfer = 0; end
          else if (mode == 2'b10) begin ph = PH_WR; m_xfer = 0; end
        end
        PH_RD:    if (mode != 2'b01) ph = PH_DRAIN;
        PH_WR:    if (mode != 2'b10) ph = PH_IDLE;
        PH_DRAIN: if (drain_done)    ph = PH_IDLE;
        default:  ph = PH_IDLE;
      endcase
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_idle();
    bit done = 0;
    mode = 2'b00; addr_valid = 0; wdata_valid = 0; rdata_ready = 1;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      if (!s_busy) done = 1;
    end
    check("return_to_idle", done, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] next_a;
    logic [31:0] wa [4];
    logic [31:0] wd [4];
    int got, first_en, first_rv, n_en, b, gap, nw, issued, busy_cyc, rv_seen;
    bit late, idle_seen;

    // ---- reset with read mode requested ----
    reset_n = 0; mode = 2'b01; addr = 32'h100; addr_valid = 1;
    wdata = 0; wdata_valid = 0; rdata_ready = 1; sram_rdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_sram_en", sram_en, 0);
    check("rst_sram_we", sram_we, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_sram_wdata", sram_wdata, 0);
    check("rst_rdata_valid", rdata_valid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_read_pause", read_pause, 1);
    check("rst_write_pause", write_pause, 1);
    check("rst_busy", busy, 0);
    check("rst_xfer_count", xfer_count, 0);
    step();
    reset_n = 1;

    // ---- streaming read 0x100..0x107 ----
    next_a = 32'h100; got = 0; first_en = -1; first_rv = -1;
    for (int k = 1; k <= 60 && got < 8; k++) begin
      addr = next_a; addr_valid = (next_a <= 32'h107);
      step();
      if (s_en && first_en < 0) first_en = k;
      if (s_rv && first_rv < 0) first_rv = k;
      if (!s_rp) next_a++;
      if (s_rv && rdata_ready) begin
        check("rd_seq", s_rdata, 32'h100 + got);
        got++;
      end
    end
    check("rd_count", got, 8);
    check("rd_first_en_cycle", first_en, 3);
    check("rd_en_to_valid", first_rv - first_en, 3);
    step();
    check("rd_xfer_total", s_xfer, 8);

    // ---- back-pressure: credits run out, then resume ----
    drain_idle();
    mode = 2'b01; rdata_ready = 0; addr_valid = 1; next_a = 32'h200; n_en = 0;
    for (int k = 0; k < 16; k++) begin
      addr = next_a;
      step();
      if (s_en) n_en++;
      if (!s_rp) next_a++;
    end
    check("stall_en_pulses", n_en, 4);
    check("stall_pause_held", s_rp, 1);
    rdata_ready = 1; got = 0;
    for (int k = 0; k < 80 && got < 8; k++) begin
      addr = next_a; addr_valid = (next_a <= 32'h207);
      step();
      if (!s_rp) next_a++;
      if (s_rv && rdata_ready) begin
        check("stall_seq", s_rdata, 32'h200 + got);
        got++;
      end
    end
    check("stall_count", got, 8);

    // ---- write with a two-cycle data gap on the third beat ----
    drain_idle();
    mode = 2'b10; b = 0; gap = 0; nw = 0;
    for (int k = 0; k < 40 && nw < 4; k++) begin
      addr = 32'h20 + b; wdata = 32'hA0 + b;
      addr_valid = (b < 4);
      wdata_valid = (b < 4) && !(b == 2 && gap < 2);
      step();
      if (s_en && s_we) begin
        if (nw < 4) begin wa[nw] = s_addr; wd[nw] = s_wdata; end
        nw++;
      end
      if (b == 2 && gap < 2) begin
        check("wr_gap_pause", s_wp, 1);
        gap++;
      end else if (!s_wp) b++;
    end
    check("wr_count", nw, 4);
    check("wr_xfer_total", s_xfer, 4);
    for (int i = 0; i < 4; i++) begin
      check("wr_addr", wa[i], 32'h20 + i);
      check("wr_data", wd[i], 32'hA0 + i);
    end

    // ---- leave read mode with two reads in flight ----
    drain_idle();
    mode = 2'b01; rdata_ready = 1; next_a = 32'h300; issued = 0;
    for (int k = 0; k < 10 && issued < 2; k++) begin
      addr = next_a; addr_valid = 1;
      step();
      if (!s_rp) begin next_a++; issued++; end
    end
    mode = 2'b00; addr_valid = 0; got = 0; late = 0; idle_seen = 0; busy_cyc = 0;
    for (int k = 0; k < 30 && !idle_seen; k++) begin
      step();
      if (s_rv) begin
        check("drain_seq", s_rdata, 32'h300 + got);
        got++;
        if (!s_busy) late = 1;
      end
      if (!s_busy) idle_seen = 1;
      else busy_cyc++;
    end
    check("drain_words", got, 2);
    check("drain_idle_with_data", late, 0);
    check("drain_reached_idle", idle_seen, 1);
    check("drain_busy_cycles", busy_cyc, 5);

    // ---- reset in the middle of a read burst ----
    drain_idle();
    mode = 2'b01; rdata_ready = 0; next_a = 32'h400; issued = 0;
    for (int k = 0; k < 10 && issued < 3; k++) begin
      addr = next_a; addr_valid = 1;
      step();
      if (!s_rp) begin next_a++; issued++; end
    end
    #1 reset_n = 0;
    #1;
    check("midrst_sram_en", sram_en, 0);
    check("midrst_sram_we", sram_we, 0);
    check("midrst_rdata_valid", rdata_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_xfer", xfer_count, 0);
    check("midrst_read_pause", read_pause, 1);
    mode = 2'b00; addr_valid = 0; rdata_ready = 1;
    repeat (3) step();
    reset_n = 1;
    rv_seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (s_rv) rv_seen++;
    end
    check("no_stale_rdata", rv_seen, 0);

    // ---- randomized traffic against the model ----
    sram_key = $urandom();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      addr        = $urandom();
      addr_valid  = ($urandom_range(0, 3) != 0);
      wdata       = $urandom();
      wdata_valid = ($urandom_range(0, 3) != 0);
      rdata_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drain_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_xfer_responder.md
Name: mem_xfer_responder

Overview:
- RAM-side responder for the address-calculation line.
- Accepts addresses (and write data) from the FFT/FIR address calculators and performs the SRAM accesses.
- Read mode (RAM -> accelerator): returns read data through a credit-protected buffer.
- Write mode (accelerator -> RAM): commits address/data pairs to SRAM.
- Drives the read/write pause signals that stall the address calculators.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_LAT, 2, SRAM read latency in cycles; legal range 1..4.
- BUF_DEPTH, 4, read-return buffer depth; power of 2, at least 2.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- mode  in  2  transfer mode: 00 idle, 01 read, 10 write, 11 reserved (treated as idle).
- addr  in  ADDR_W  address from the calculator line.
- addr_valid  in  1  addr is driven (some tri-state enable is active).
- wdata  in  DATA_W  write data from the accelerator.
- wdata_valid  in  1  wdata is valid.
- read_pause  out  1  stall the read address calculator.
- write_pause  out  1  stall the write address calculator.
- rdata  out  DATA_W  head of the read-return buffer.
- rdata_valid  out  1  rdata is valid.
- rdata_ready  in  1  accelerator consumes rdata.
- sram_en  out  1  SRAM access strobe.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data.
- xfer_count  out  32  accesses completed since leaving IDLE.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset values:
  - state = IDLE.
  - sram_en, sram_we, sram_addr, sram_wdata = 0.
  - Buffer empty, so rdata_valid = 0 and rdata = 0.
  - In-flight count = 0; xfer_count = 0.
  - read_pause = 1, write_pause = 1, busy = 0.
- FSM states: IDLE, READ, WRITE, DRAIN.
  - IDLE -> READ when mode = 01; IDLE -> WRITE when mode = 10. xfer_count clears on either transition.
  - READ -> DRAIN when mode != 01.
  - WRITE -> IDLE when mode != 10.
  - DRAIN -> IDLE when in-flight = 0 and buffer empty. DRAIN ignores mode until exit.
- Read issue:
  - Condition: state = READ, addr_valid = 1, and (in-flight + occupancy) < BUF_DEPTH.
  - Next edge: sram_en = 1, sram_we = 0, sram_addr = addr.
  - read_pause = NOT(issue condition); combinational, so the calculator advances on the same edge.
- Read return:
  - A RD_LAT-stage valid shift register tracks in-flight reads.
  - sram_rdata is pushed into the buffer on the edge RD_LAT cycles after the sram_en cycle.
  - rdata_valid is high from the next cycle. Issue-to-rdata_valid latency = RD_LAT + 1 cycles.
- Pop: rdata_valid & rdata_ready. A simultaneous push and pop is legal at any occupancy.
- Overflow: the credit rule makes overflow impossible; an assertion covers it.
- Write accept:
  - Condition: state = WRITE, addr_valid = 1, wdata_valid = 1.
  - Next edge: sram_en = 1, sram_we = 1, sram_addr = addr, sram_wdata = wdata.
  - write_pause = NOT(accept condition).
- Pause in other states: read_pause = 1 outside READ; write_pause = 1 outside WRITE.
- sram_en = 0 on any cycle without an issue or accept. sram_we = 0 whenever sram_en = 0.
- xfer_count increments on each buffer pop (read) or each write accept; wraps modulo 2^32.
- mode = 11: handled as idle in IDLE; causes READ -> DRAIN and WRITE -> IDLE.
- Reset mid-operation: in-flight reads are discarded and the buffer is flushed. SRAM strobes deassert asynchronously.

Decomposition:
- Shared package mem_xfer_pkg holds:
  - State encoding (2-bit localparams).
  - Mode codes MODE_IDLE, MODE_READ, MODE_WRITE.
  - RD_LAT legal-range check constants.
- One sub-module: rd_return_fifo, a synchronous FIFO of BUF_DEPTH x DATA_W with push, pop, occupancy, full and empty, reset by reset_n.

Test Plan:
- Reset with mode = 01 and addr_valid = 1 held -> all outputs at reset values. The first sram_en appears on the edge after reset_n deasserts and the state reaches READ.
- Read mode, RD_LAT = 2, addresses 0x100..0x107 at one per cycle, rdata_ready = 1, SRAM model returns data = addr -> rdata sequence 0x100..0x107, first valid 3 cycles after the first sram_en, xfer_count = 8.
- Read mode with rdata_ready = 0 -> exactly 4 sram_en pulses, then read_pause stays 1. Raising rdata_ready resumes issue one credit per pop with no data loss.
- Write mode, addr 0x20..0x23 with wdata 0xA0..0xA3, wdata_valid dropped on the 3rd beat for 2 cycles -> write_pause = 1 during the gap, 4 SRAM writes with correct pairs, xfer_count = 4.
- Mode switches 01 -> 00 with 2 reads in flight -> state passes through DRAIN, both data words delivered, busy falls only after the buffer empties.
- reset_n asserted mid-read with 3 in flight -> outputs clear immediately. After release, no stale rdata_valid appears.
